controlador_barrido_display: RTL and testbench

Scan controller for the four-digit seven-segment display. It time-multiplexes the digit-select/enable multiplexer: it generates the digit index `o_N_cifra`, a per-slot blanking window against ghosting, and double-buffered digit data on `o_Datos1..4`. Data loads are accepted at any time and take effect only at a frame boundary, so a frame never shows mixed old and new digits. It sits between the application logic (counters, BCD converters) and the digit multiplexer / anode drivers.

---
 rtl/controlador_barrido_display.sv | 136 +++++++++++++
 tb/tb_controlador_barrido_display.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/controlador_barrido_display.sv
// controlador_barrido_display: scan controller for a four-digit seven-segment display.
// Drives the digit index, a per-slot blanking window and double-buffered digit data.
// Loads land in a pending register and are committed at the frame boundary
// (or immediately when idle or on the boundary cycle itself).
// Optional macro SUPRIMIR_CEROS_EN: blanks leading-zero digits 2..4.
module controlador_barrido_display #(
   parameter int DIV_CICLOS   = 50000,
   parameter int BLANK_CICLOS = 500
) (
   input  logic        i_Clk,
   input  logic        i_Reset,
   input  logic        i_Habilitar,
   input  logic        i_Cargar,
   input  logic [15:0] i_Dato,
   output logic [1:0]  o_N_cifra,
   output logic [3:0]  o_Datos1,
   output logic [3:0]  o_Datos2,
   output logic [3:0]  o_Datos3,
   output logic [3:0]  o_Datos4,
   output logic        o_Blank,
   output logic        o_Ocupado,
   output logic        o_Fin_cuadro
);

   localparam int CW = $clog2(DIV_CICLOS);
   localparam logic [CW-1:0] CNT_FIN = CW'(DIV_CICLOS - 1);
   localparam logic [CW-1:0] CNT_BLK = CW'(BLANK_CICLOS - 1);

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} estado_t;

   estado_t       est_q, est_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    n_q, n_d;
   logic [15:0]   dat_q, dat_d;
   logic [15:0]   pend_q, pend_d;
   logic          ocup_q, ocup_d;
   logic          blank_q, blank_d;
   logic          fin_q, fin_d;
   logic          frontera;

   assign frontera = (est_q == SHOW) && (n_q == 2'd3) && (cnt_q == CNT_FIN);

   // Next-state and next-output computation; outputs are registered from the next state
   // so o_Blank and o_N_cifra change on the same edge.
   always_comb begin
      est_d  = est_q;
      cnt_d  = cnt_q;
      n_d    = n_q;
      dat_d  = dat_q;
      pend_d = pend_q;
      ocup_d = ocup_q;
      fin_d  = 1'b0;
      if (!i_Habilitar) begin
         // Stop scanning: commit anything pending, a simultaneous load wins.
         est_d  = IDLE;
         cnt_d  = '0;
         n_d    = 2'd0;
         if (ocup_q) dat_d = pend_q;
         ocup_d = 1'b0;
         if (i_Cargar) dat_d = i_Dato;
      end else begin
         unique case (est_q)
            IDLE: begin
               est_d = BLANK;
               cnt_d = '0;
               n_d   = 2'd0;
               if (i_Cargar) dat_d = i_Dato;
            end
            BLANK: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_BLK) est_d = SHOW;
            end
            SHOW: begin
               if (cnt_q == CNT_FIN) begin
                  cnt_d = '0;
                  n_d   = n_q + 2'd1;
                  est_d = BLANK;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: est_d = IDLE;
         endcase
         if (est_q != IDLE) begin
            if (frontera) begin
               fin_d = 1'b1;
               if (ocup_q) dat_d = pend_q;
               ocup_d = 1'b0;
               if (i_Cargar) dat_d = i_Dato;
            end else if (i_Cargar) begin
               pend_d = i_Dato;
               ocup_d = 1'b1;
            end
         end
      end
      blank_d = (est_d != SHOW);
`ifdef SUPRIMIR_CEROS_EN
      // Digit n+1 is a leading zero when it and all more-significant digits are 0.
      if ((est_d == SHOW) && (n_d != 2'd0) && ((dat_d >> {n_d, 2'b00}) == 16'd0))
         blank_d = 1'b1;
`endif
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         est_q   <= IDLE;
         cnt_q   <= '0;
         n_q     <= 2'd0;
         dat_q   <= 16'd0;
         pend_q  <= 16'd0;
         ocup_q  <= 1'b0;
         blank_q <= 1'b1;
         fin_q   <= 1'b0;
      end else begin
         est_q   <= est_d;
         cnt_q   <= cnt_d;
         n_q     <= n_d;
         dat_q   <= dat_d;
         pend_q  <= pend_d;
         ocup_q  <= ocup_d;
         blank_q <= blank_d;
         fin_q   <= fin_d;
      end
   end

   assign o_N_cifra    = n_q;
   assign o_Datos1     = dat_q[3:0];
   assign o_Datos2     = dat_q[7:4];
   assign o_Datos3     = dat_q[11:8];
   assign o_Datos4     = dat_q[15:12];
   assign o_Blank      = blank_q;
   assign o_Ocupado    = ocup_q;
   assign o_Fin_cuadro = fin_q;

endmodule

// File: tb/tb_controlador_barrido_display.sv
// Randomized bench for controlador_barrido_display against a position-in-run reference model.
module tb_controlador_barrido_display;

   localparam int DIV = 8;
   localparam int BLK = 2;

   logic        clk = 1'b0;
   logic        rst, hab, carg;
   logic [15:0] dato;
   logic [1:0]  n_cifra;
   logic [3:0]  d1, d2, d3, d4;
   logic        blank, ocup, fin;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: position p counts cycles since the run started.
   bit          m_en;
   int          m_p;
   logic [15:0] m_disp, m_pend;
   bit          m_busy, m_fin;

   controlador_barrido_display #(.DIV_CICLOS(DIV), .BLANK_CICLOS(BLK)) dut (
      .i_Clk(clk), .i_Reset(rst), .i_Habilitar(hab), .i_Cargar(carg), .i_Dato(dato),
      .o_N_cifra(n_cifra), .o_Datos1(d1), .o_Datos2(d2), .o_Datos3(d3), .o_Datos4(d4),
      .o_Blank(blank), .o_Ocupado(ocup), .o_Fin_cuadro(fin)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (p=%0d en=%0d)", tag, obs, exp_v, m_p, m_en);
      end
   endtask

   function automatic bit supp(input int slot, input logic [15:0] v);
`ifdef SUPRIMIR_CEROS_EN
      return (slot != 0) && ((v >> (4 * slot)) == 16'd0);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_edge(input bit r, input bit h, input bit c, input logic [15:0] d);
      bit bnd;
      if (r) begin
         m_en = 0; m_p = 0; m_disp = 0; m_pend = 0; m_busy = 0; m_fin = 0;
      end else if (!h) begin
         if (m_busy) m_disp = m_pend;
         if (c) m_disp = d;
         m_en = 0; m_p = 0; m_busy = 0; m_fin = 0;
      end else if (!m_en) begin
         if (c) m_disp = d;
         m_en = 1; m_p = 0; m_fin = 0;
      end else begin
         bnd = (m_p % (4 * DIV)) == (4 * DIV - 1);
         m_p++;
         m_fin = bnd;
         if (bnd) begin
            if (m_busy) m_disp = m_pend;
            m_busy = 0;
            if (c) m_disp = d;
         end else if (c) begin
            m_pend = d;
            m_busy = 1;
         end
      end
   endtask

   task automatic check_all();
      int slot;
      bit eb;
      slot = m_en ? (m_p / DIV) % 4 : 0;
      eb = !m_en || ((m_p % DIV) < BLK) || supp(slot, m_disp);
      chk("n_cifra", 32'(n_cifra), 32'(slot));
      chk("blank", 32'(blank), 32'(eb));
      chk("datos", 32'({d4, d3, d2, d1}), 32'(m_disp));
      chk("ocupado", 32'(ocup), 32'(m_busy));
      chk("fin_cuadro", 32'(fin), 32'(m_fin));
   endtask

   task automatic tick(input bit r, input bit h, input bit c, input logic [15:0] d);
      rst = r; hab = h; carg = c; dato = d;
      @(posedge clk);
      model_edge(r, h, c, d);
      #1;
      check_all();
   endtask

   // Run enabled, idle-input cycles until the model reaches position target (mod frame).
   task automatic run_to(input int target);
      int guard = 0;
      while ((m_p % (4 * DIV)) != target && guard < 100) begin
         tick(0, 1, 0, 16'h0);
         guard++;
      end
      chk("run_to_bound", 32'(guard < 100), 32'd1);
   endtask

   initial begin
      rst = 1; hab = 0; carg = 0; dato = 0;
      m_en = 0; m_p = 0; m_disp = 0; m_pend = 0; m_busy = 0; m_fin = 0;
      tick(1, 0, 0, 16'h0);
      tick(1, 0, 0, 16'h0);
      // Reset state against fixed constants.
      chk("rst_n_cifra", 32'(n_cifra), 32'd0);
      chk("rst_blank", 32'(blank), 32'd1);
      chk("rst_datos", 32'({d4, d3, d2, d1}), 32'd0);
      chk("rst_ocupado", 32'(ocup), 32'd0);
      chk("rst_fin", 32'(fin), 32'd0);

      // Free-running scan for two frames.
      repeat (70) tick(0, 1, 0, 16'h0);
      // Mid-frame load in slot 1.
      run_to(DIV + 3);
      tick(0, 1, 1, 16'h1234);
      chk("busy_after_load", 32'(ocup), 32'd1);
      run_to(4 * DIV - 1);
      tick(0, 1, 0, 16'h0);
      chk("commit_1234", 32'({d4, d3, d2, d1}), 32'h1234);
      // Last load wins.
      run_to(5);
      tick(0, 1, 1, 16'h1111);
      run_to(20);
      tick(0, 1, 1, 16'h2222);
      run_to(0);
      chk("last_wins", 32'({d4, d3, d2, d1}), 32'h2222);
      // Load on the boundary cycle.
      run_to(4 * DIV - 1);
      tick(0, 1, 1, 16'hABCD);
      chk("bnd_direct", 32'({d4, d3, d2, d1}), 32'hABCD);
      chk("bnd_not_busy", 32'(ocup), 32'd0);
      // Drop enable in slot 2 with a pending value, then re-enable.
      run_to(2 * DIV + 4);
      tick(0, 1, 1, 16'h5678);
      tick(0, 0, 0, 16'h0);
      chk("drop_blank", 32'(blank), 32'd1);
      chk("drop_commit", 32'({d4, d3, d2, d1}), 32'h5678);
      tick(0, 0, 1, 16'h4321);
      chk("idle_direct", 32'({d4, d3, d2, d1}), 32'h4321);
      repeat (40) tick(0, 1, 0, 16'h0);
      // Leading-zero patterns (suppressed only when the macro is set).
      run_to(4 * DIV - 1);
      tick(0, 1, 1, 16'h0050);
      repeat (32) tick(0, 1, 0, 16'h0);
      run_to(4 * DIV - 1);
      tick(0, 1, 1, 16'h0000);
      repeat (32) tick(0, 1, 0, 16'h0);

      // Randomized traffic, including occasional disables and resets.
      for (int i = 0; i < 1500; i++) begin
         tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) != 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) == 0) ? 16'(($urandom_range(0, 255)) << 4) : 16'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
